// File: rtl/if_fetch_ctrl_if.sv
// Icache request/response bus between the fetch controller (master) and the instruction cache (slave).
// Handshake: a request transfers on any cycle with ic_req & ic_ready; the single outstanding request
// completes on the first later cycle with ic_valid = 1, and ic_rdata is meaningful only on that cycle.
interface if_fetch_ctrl_if;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_ready;
  logic        ic_valid;
  logic [31:0] ic_rdata;

  modport master (output ic_req, output ic_addr, input ic_ready, input ic_valid, input ic_rdata);
  modport slave  (input ic_req, input ic_addr, output ic_ready, output ic_valid, output ic_rdata);
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: one outstanding icache request, stall buffer, redirect with late-response drop.
// Optional performance counters (perf_fetched, perf_wait) are built when IFETCH_PERF_EN is defined.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallF,
  input  logic            redirect,
  input  logic [31:0]     redirect_pc,
  if_fetch_ctrl_if.master ic,
  output logic [31:0]     instrF,
  output logic [31:0]     PCF,
  output logic [31:0]     PCplus4F,
  output logic            ifid_hold,
  output logic            ifid_bubble,
  output logic [1:0]      o_dbg_state
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_wait
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [31:0] RESET_PC_AL = RESET_PC & 32'hFFFF_FFFC;

  state_t      r_state, w_state_nxt, w_state;
  logic [31:0] r_pc, w_pc_nxt, w_pc, w_redir_pc;
  logic        r_drop, w_drop_nxt;
  logic [31:0] r_buf, w_buf_nxt;
  logic        w_fetch_valid, w_consume;

  // Outputs already show the reset state while rst is low, so a response arriving then is ignored.
  assign w_state    = rst ? r_state : S_IDLE;
  assign w_pc       = rst ? r_pc : RESET_PC_AL;
  assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC_AL;
      r_drop  <= 1'b0;
      r_buf   <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_drop  <= w_drop_nxt;
      r_buf   <= w_buf_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_drop_nxt    = r_drop;
    w_buf_nxt     = r_buf;
    w_fetch_valid = 1'b0;
    w_consume     = 1'b0;
    ic.ic_req     = 1'b0;
    case (w_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        ic.ic_req = ~redirect;
        if (redirect) begin
          w_pc_nxt = w_redir_pc;
        end else if (ic.ic_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          // Without a response yet, stay and swallow the stale word when it finally shows up.
          w_pc_nxt = w_redir_pc;
          if (ic.ic_valid) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_drop_nxt = 1'b1;
          end
        end else if (ic.ic_valid) begin
          if (r_drop) begin
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else begin
            w_fetch_valid = 1'b1;
            if (stallF) begin
              w_buf_nxt   = ic.ic_rdata;
              w_state_nxt = S_HOLD;
            end else begin
              w_consume   = 1'b1;
              w_state_nxt = S_REQ;
            end
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = S_REQ;
        end else begin
          w_fetch_valid = 1'b1;
          if (!stallF) begin
            w_consume   = 1'b1;
            w_state_nxt = S_REQ;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_consume) begin
      w_pc_nxt = r_pc + 32'd4;
    end
  end

  assign ic.ic_addr  = w_pc;
  assign PCF         = w_pc;
  assign PCplus4F    = w_pc + 32'd4;
  assign instrF      = w_fetch_valid ? ((w_state == S_HOLD) ? r_buf : ic.ic_rdata) : 32'h0;
  assign ifid_hold   = stallF;
  assign ifid_bubble = ~w_fetch_valid & ~stallF;
  assign o_dbg_state = w_state;

`ifdef IFETCH_PERF_EN
  logic [31:0] r_perf_fetched, r_perf_wait;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_fetched <= 32'h0;
      r_perf_wait    <= 32'h0;
    end else begin
      if (w_consume) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (r_state == S_WAIT) r_perf_wait <= r_perf_wait + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_wait    = r_perf_wait;
`endif

endmodule
